stream_fifo_ram_ctrl: RTL and testbench



---
 rtl/stream_fifo_ram_ctrl_if.sv | 39 +++
 rtl/stream_fifo_ram_ctrl.sv | 112 +++++++++++
 tb/tb_stream_fifo_ram_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/stream_fifo_ram_ctrl_if.sv
// ---------------------------------------------------------------------------
// stream_fifo_ram_ctrl_if
// Bundles the signals of stream_fifo_ram_ctrl that cross to other blocks:
//   push side : push_valid, push_ready, push_payload
//   pop side  : pop_valid, pop_ready, pop_payload, occupancy
//   RAM side  : ram_wr_en, ram_wr_addr, ram_wr_data, ram_rd_addr, ram_rd_data
// Modports:
//   slave  - the FIFO controller
//   master - the surroundings (producer, consumer and RAM macro)
// ---------------------------------------------------------------------------
interface stream_fifo_ram_ctrl_if #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 32
);
  logic                  push_valid;
  logic                  push_ready;
  logic [WIDTH-1:0]      push_payload;
  logic                  pop_valid;
  logic                  pop_ready;
  logic [WIDTH-1:0]      pop_payload;
  logic [DEPTH_LOG2:0]   occupancy;
  logic                  ram_wr_en;
  logic [DEPTH_LOG2-1:0] ram_wr_addr;
  logic [WIDTH-1:0]      ram_wr_data;
  logic [DEPTH_LOG2-1:0] ram_rd_addr;
  logic [WIDTH-1:0]      ram_rd_data;

  modport slave (
    input  push_valid, push_payload, pop_ready, ram_rd_data,
    output push_ready, pop_valid, pop_payload, occupancy,
           ram_wr_en, ram_wr_addr, ram_wr_data, ram_rd_addr
  );

  modport master (
    output push_valid, push_payload, pop_ready, ram_rd_data,
    input  push_ready, pop_valid, pop_payload, occupancy,
           ram_wr_en, ram_wr_addr, ram_wr_data, ram_rd_addr
  );
endinterface

// File: rtl/stream_fifo_ram_ctrl.sv
// ---------------------------------------------------------------------------
// stream_fifo_ram_ctrl
// Valid/ready stream FIFO controller for an external RAM of 2**DEPTH_LOG2
// words with one synchronous write port and one asynchronous read port.
// Owns the write/read pointers, occupancy and the pop-side presentation.
//
// Ports:
//   clk     - single clock, all state on the rising edge
//   resetn  - synchronous active-low reset
//   flush   - synchronous clear of all contents
//   bus     - stream_fifo_ram_ctrl_if.slave (push, pop, occupancy, RAM ports)
//
// Optional feature macro: FIFO_POP_REG_EN
//   defined   : registered output stage (data + valid), capacity 2**DEPTH_LOG2+1
//   undefined : pop taken straight from the RAM read port, capacity 2**DEPTH_LOG2
// ---------------------------------------------------------------------------
module stream_fifo_ram_ctrl #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 32
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   flush,
  stream_fifo_ram_ctrl_if.slave  bus
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  typedef logic [DEPTH_LOG2:0] ptr_t;

  ptr_t r_wr_ptr;
  ptr_t r_rd_ptr;
  logic r_push_ready;

  ptr_t w_ram_cnt;
  ptr_t w_ram_cnt_nxt;
  logic w_ram_empty;
  logic w_push_fire;
  logic w_pop_fire;
  logic w_rd_adv;

  // Pointers carry an extra wrap bit, so their difference is the RAM count
  // even when the low bits are equal.
  assign w_ram_cnt   = r_wr_ptr - r_rd_ptr;
  assign w_ram_empty = (r_wr_ptr == r_rd_ptr);
  assign w_push_fire = bus.push_valid && r_push_ready;

  // push_ready is registered from the count the RAM will hold next cycle, so
  // a pop while full only opens a slot one cycle later.
  assign w_ram_cnt_nxt = w_ram_cnt + ptr_t'(w_push_fire) - ptr_t'(w_rd_adv);

  assign bus.push_ready  = r_push_ready;
  assign bus.ram_wr_en   = w_push_fire;
  assign bus.ram_wr_addr = r_wr_ptr[DEPTH_LOG2-1:0];
  assign bus.ram_wr_data = bus.push_payload;
  assign bus.ram_rd_addr = r_rd_ptr[DEPTH_LOG2-1:0];

`ifdef FIFO_POP_REG_EN
  logic             r_out_vld;
  logic [WIDTH-1:0] r_out_data;

  assign w_pop_fire = r_out_vld && bus.pop_ready;
  // Refill the output stage whenever it is empty or being emptied this cycle.
  assign w_rd_adv   = !w_ram_empty && (!r_out_vld || w_pop_fire);

  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      r_out_vld <= 1'b0;
    end else if (w_rd_adv) begin
      r_out_vld <= 1'b1;
    end else if (w_pop_fire) begin
      r_out_vld <= 1'b0;
    end
  end

  // Data register is not reset; r_out_vld qualifies it.
  always_ff @(posedge clk) begin
    if (w_rd_adv) begin
      r_out_data <= bus.ram_rd_data;
    end
  end

  assign bus.pop_valid   = r_out_vld;
  assign bus.pop_payload = r_out_data;
  assign bus.occupancy   = w_ram_cnt + ptr_t'(r_out_vld);
`else
  assign w_pop_fire      = !w_ram_empty && bus.pop_ready;
  assign w_rd_adv        = w_pop_fire;
  assign bus.pop_valid   = !w_ram_empty;
  assign bus.pop_payload = bus.ram_rd_data;
  assign bus.occupancy   = w_ram_cnt;
`endif

  // Control state: pointers and push_ready. Flush behaves like reset here, so
  // a push offered in the flush cycle is written to RAM but never counted.
  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_push_ready <= 1'b0;
    end else begin
      if (w_push_fire) begin
        r_wr_ptr <= r_wr_ptr + ptr_t'(1);
      end
      if (w_rd_adv) begin
        r_rd_ptr <= r_rd_ptr + ptr_t'(1);
      end
      r_push_ready <= (w_ram_cnt_nxt < ptr_t'(DEPTH));
    end
  end

endmodule

// File: tb/tb_stream_fifo_ram_ctrl.sv
module tb_stream_fifo_ram_ctrl;

  localparam int DL    = 2;
  localparam int W     = 32;
  localparam int DEPTH = 1 << DL;
`ifdef FIFO_POP_REG_EN
  localparam int CAP   = DEPTH + 1;
`else
  localparam int CAP   = DEPTH;
`endif

  logic clk;
  logic resetn;
  logic flush;

  stream_fifo_ram_ctrl_if #(.DEPTH_LOG2(DL), .WIDTH(W)) bus ();

  stream_fifo_ram_ctrl #(.DEPTH_LOG2(DL), .WIDTH(W)) u_dut (
    .clk    (clk),
    .resetn (resetn),
    .flush  (flush),
    .bus    (bus)
  );

  // External RAM: synchronous write, asynchronous read.
  logic [W-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (bus.ram_wr_en) mem[bus.ram_wr_addr] <= bus.ram_wr_data;
  end
  assign bus.ram_rd_data = mem[bus.ram_rd_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: words stored in RAM as an ordered queue, an optional
  // head register, and the registered push_ready.
  logic [W-1:0] m_ram[$];
  bit           m_sv;
  logic [W-1:0] m_sd;
  bit           m_ready;
  int           m_wcnt;
  bit           m_known;
  bit           last_wfire;

  task automatic step(input bit pv, input logic [W-1:0] pd, input bit pr,
                      input bit fl, input bit rn);
    bit           exp_pv;
    logic [W-1:0] exp_pd;
    int           exp_occ;
    bit           wfire;
    bit           pfire;
    @(negedge clk);
    resetn           = rn;
    flush            = fl;
    bus.push_valid   = pv;
    bus.push_payload = pd;
    bus.pop_ready    = pr;
    #1;
    exp_pd = '0;
`ifdef FIFO_POP_REG_EN
    exp_pv  = m_sv;
    exp_pd  = m_sd;
    exp_occ = m_ram.size() + int'(m_sv);
`else
    exp_pv  = (m_ram.size() != 0);
    if (exp_pv) exp_pd = m_ram[0];
    exp_occ = m_ram.size();
`endif
    wfire = pv && m_ready;
    last_wfire = wfire;
    if (m_known) begin
      check("push_ready", bus.push_ready, m_ready);
      check("pop_valid", bus.pop_valid, exp_pv);
      check("occupancy", bus.occupancy, exp_occ);
      check("ram_wr_en", bus.ram_wr_en, wfire);
      if (exp_pv) check("pop_payload", bus.pop_payload, exp_pd);
      if (wfire) begin
        check("ram_wr_addr", bus.ram_wr_addr, m_wcnt % DEPTH);
        check("ram_wr_data", bus.ram_wr_data, pd);
      end
    end
    // Model state after the coming rising edge.
    if (!rn || fl) begin
      m_ram.delete();
      m_sv    = 1'b0;
      m_ready = 1'b0;
      m_wcnt  = 0;
      if (!rn) m_known = 1'b1;
    end else begin
      pfire = exp_pv && pr;
`ifdef FIFO_POP_REG_EN
      if (m_ram.size() != 0 && (!m_sv || pfire)) begin
        m_sd = m_ram[0];
        m_ram.delete(0);
        m_sv = 1'b1;
      end else if (pfire) begin
        m_sv = 1'b0;
      end
`else
      if (pfire) m_ram.delete(0);
`endif
      if (wfire) begin
        m_ram.push_back(pd);
        m_wcnt++;
      end
      m_ready = (m_ram.size() < DEPTH);
    end
  endtask

  logic [W-1:0] val;

  initial begin
    resetn = 1'b0;
    flush  = 1'b0;
    bus.push_valid   = 1'b0;
    bus.push_payload = '0;
    bus.pop_ready    = 1'b0;
    m_known = 1'b0;
    m_sv    = 1'b0;
    m_ready = 1'b0;
    m_wcnt  = 0;

    // Reset, then one word at cycle 10.
    repeat (3) step(0, '0, 0, 0, 0);
    repeat (6) step(0, '0, 0, 0, 1);
    step(1, 32'hA5A5A5A5, 0, 0, 1);
    check("single_wr_seen", last_wfire, 1'b1);
`ifdef FIFO_POP_REG_EN
    step(0, '0, 0, 0, 1);
`endif
    step(0, '0, 0, 0, 1);
    check("single_pop_valid", bus.pop_valid, 1'b1);
    check("single_payload", bus.pop_payload, 32'hA5A5A5A5);
    check("single_occ", bus.occupancy, 1);
    repeat (4) step(0, '0, 1, 0, 1);

    // Fill with pop_ready low, then drain in order.
    val = 0;
    repeat (CAP + 3) begin
      step(1, val, 0, 0, 1);
      if (last_wfire) val++;
    end
    step(0, '0, 0, 0, 1);
    check("fill_occ", bus.occupancy, CAP);
    check("fill_ready", bus.push_ready, 1'b0);
    check("fill_head", bus.pop_payload, 0);
    repeat (CAP + 2) step(0, '0, 1, 0, 1);
    check("drain_occ", bus.occupancy, 0);

    // Full with simultaneous push and pop.
    repeat (CAP + 3) begin
      step(1, val, 0, 0, 1);
      if (last_wfire) val++;
    end
    repeat (6) begin
      step(1, val, 1, 0, 1);
      if (last_wfire) val++;
    end
    repeat (CAP + 2) step(0, '0, 1, 0, 1);

    // Wrap-around: one push and one pop per cycle.
    val = 32'h100;
    repeat (24) begin
      step(1, val, 1, 0, 1);
      if (last_wfire) val++;
    end
    repeat (CAP + 2) step(0, '0, 1, 0, 1);

    // Flush with three words held and a push offered.
    repeat (3) begin
      step(1, val, 0, 0, 1);
      val++;
    end
    step(1, 32'hDEADBEEF, 0, 1, 1);
    step(1, 32'h0BADF00D, 0, 0, 1);
    check("flush_occ", bus.occupancy, 0);
    check("flush_pop_valid", bus.pop_valid, 1'b0);
    check("flush_ready", bus.push_ready, 1'b0);
    step(1, 32'h12345678, 0, 0, 1);
    repeat (3) step(0, '0, 0, 0, 1);
    check("flush_head", bus.pop_payload, 32'h12345678);
    repeat (3) step(0, '0, 1, 0, 1);

    // Reset mid-stream with two words held.
    repeat (2) begin
      step(1, val, 0, 0, 1);
      val++;
    end
    step(1, val, 1, 0, 0);
    step(0, '0, 1, 0, 1);
    check("rst_occ", bus.occupancy, 0);
    check("rst_pop_valid", bus.pop_valid, 1'b0);
    check("rst_ready", bus.push_ready, 1'b0);
    repeat (3) step(0, '0, 1, 0, 1);

    // Randomized traffic with occasional flush and reset.
    repeat (3000) begin
      step(bit'($urandom_range(0, 3) != 0), $urandom, bit'($urandom_range(0, 2) != 0),
           bit'($urandom_range(0, 63) == 0), bit'($urandom_range(0, 127) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
